lvds_rx_framer: RTL and testbench

Parametrised successor to the single-rate LVDS modem receiver. It deserialises the 2-bit DDR stream from the modem into frames of configurable length and checks the I and Q sync symbols. It requires a configurable number of consecutive good frames before declaring lock, and pushes one word per frame into the RX FIFO only while locked. It also keeps saturating counters for sync errors and FIFO overflows, and sits between the LVDS input pins and the RX async FIFO.

---
 rtl/lvds_rx_framer.sv | 188 ++++++++++++++++++
 tb/tb_lvds_rx_framer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_framer.sv
// lvds_rx_framer: deserialises a 2-bit-per-edge DDR stream into frames of
// 2*HALF_CYCLES symbols, checks the I/Q sync symbols and tracks lock.
// While locked, one word per completed frame is pushed into the RX FIFO.
// Saturating counters record sync errors and frames dropped on FIFO full.
module lvds_rx_framer #(
  parameter int         HALF_CYCLES = 8,
  parameter int         LOCK_FRAMES = 2,
  parameter int         CNT_W       = 16,
  parameter logic [1:0] SYNC_I      = 2'b10,
  parameter logic [1:0] SYNC_Q      = 2'b01
) (
  input  logic                     i_ddr_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic [1:0]               i_ddr_data,
  input  logic                     i_sync_input,
  input  logic                     i_fifo_full,
  input  logic                     i_cnt_clear,
  output logic                     o_fifo_write_clk,
  output logic                     o_fifo_push,
  output logic [4*HALF_CYCLES-1:0] o_fifo_data,
  output logic                     o_locked,
  output logic [CNT_W-1:0]         o_sync_err_cnt,
  output logic [CNT_W-1:0]         o_overflow_cnt,
  output logic [1:0]               o_debug_state
);

  localparam int W  = 4 * HALF_CYCLES;
  localparam int PW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [PW-1:0] PH_INIT = PW'(HALF_CYCLES - 1);
  localparam logic [PW-1:0] PH_Q    = PW'(HALF_CYCLES - 2);

  typedef enum logic [1:0] {
    HUNT    = 2'b00,
    I_PHASE = 2'b01,
    Q_PHASE = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ph_q, ph_d;         // edges left in the current half
  logic [W-3:0]      sr_q, sr_d;         // every frame bit except the final two
  logic              mark_q, mark_d;     // i_sync_input captured at frame start
  logic [3:0]        good_q, good_d;
  logic              cmpl_q, cmpl_d;     // previous edge completed a frame
  logic              locked_q, locked_d;
  logic              push_q, push_d;
  logic [W-1:0]      data_q, data_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d;
  logic              err_inc, ovf_inc, lock_now;
  logic [W-1:0]      word;

  assign o_fifo_write_clk = i_ddr_clk;
  assign o_fifo_push      = push_q;
  assign o_fifo_data      = data_q;
  assign o_locked         = locked_q;
  assign o_sync_err_cnt   = err_q;
  assign o_overflow_cnt   = ovf_q;
  assign o_debug_state    = state_q;

  // State register
  always_ff @(posedge i_ddr_clk or posedge i_rst) begin
    if (i_rst) state_q <= HUNT;
    else       state_q <= state_d;
  end

  // Next-state: disable always drops back to hunting
  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT:    if (i_ddr_data == SYNC_I) state_d = I_PHASE;
        I_PHASE: if (ph_q == '0) state_d = (i_ddr_data == SYNC_Q) ? Q_PHASE : HUNT;
        Q_PHASE: if (ph_q == '0) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Datapath, lock tracking, push decision and counter updates
  always_comb begin
    ph_d     = ph_q;
    sr_d     = sr_q;
    mark_d   = mark_q;
    good_d   = good_q;
    locked_d = locked_q;
    cmpl_d   = 1'b0;
    push_d   = 1'b0;
    data_d   = data_q;
    err_inc  = 1'b0;
    ovf_inc  = 1'b0;
    lock_now = locked_q;
    // last edge carries only one payload bit; the marker fills bit 0
    word     = {sr_q, i_ddr_data[1], mark_q};
    if (!i_enable) begin
      ph_d     = PH_INIT;
      good_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          if (i_ddr_data == SYNC_I) begin
            sr_d   = {{(W-4){1'b0}}, SYNC_I};
            mark_d = i_sync_input;
            ph_d   = PH_INIT;
          end else if (locked_q && cmpl_q) begin
            // a locked stream must carry SYNC_I right after each frame
            err_inc  = 1'b1;
            locked_d = 1'b0;
            good_d   = '0;
          end
        end
        I_PHASE: begin
          sr_d = {sr_q[W-5:0], i_ddr_data};
          if (ph_q != '0) begin
            ph_d = ph_q - PW'(1);
          end else if (i_ddr_data == SYNC_Q) begin
            ph_d = PH_Q;
          end else begin
            err_inc  = 1'b1;
            locked_d = 1'b0;
            good_d   = '0;
            ph_d     = PH_INIT;
          end
        end
        Q_PHASE: begin
          if (ph_q != '0) begin
            sr_d = {sr_q[W-5:0], i_ddr_data};
            ph_d = ph_q - PW'(1);
          end else begin
            data_d = word;
            cmpl_d = 1'b1;
            ph_d   = PH_INIT;
            if (!locked_q) begin
              good_d = good_q + 4'd1;
              if (good_d == 4'(LOCK_FRAMES)) begin
                locked_d = 1'b1;
                lock_now = 1'b1;
              end
            end
            if (lock_now) begin
              if (i_fifo_full) ovf_inc = 1'b1;
              else             push_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    // clear has priority over a coincident increment
    err_d = err_q;
    if (i_cnt_clear) err_d = '0;
    else if (err_inc && err_q != '1) err_d = err_q + CNT_W'(1);
    ovf_d = ovf_q;
    if (i_cnt_clear) ovf_d = '0;
    else if (ovf_inc && ovf_q != '1) ovf_d = ovf_q + CNT_W'(1);
  end

  // Datapath registers
  always_ff @(posedge i_ddr_clk or posedge i_rst) begin
    if (i_rst) begin
      ph_q     <= PH_INIT;
      sr_q     <= '0;
      mark_q   <= 1'b0;
      good_q   <= '0;
      cmpl_q   <= 1'b0;
      locked_q <= 1'b0;
      push_q   <= 1'b0;
      data_q   <= '0;
      err_q    <= '0;
      ovf_q    <= '0;
    end else begin
      ph_q     <= ph_d;
      sr_q     <= sr_d;
      mark_q   <= mark_d;
      good_q   <= good_d;
      cmpl_q   <= cmpl_d;
      locked_q <= locked_d;
      push_q   <= push_d;
      data_q   <= data_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_lvds_rx_framer.sv
// Bench for lvds_rx_framer: frame-position reference model, per-cycle trace
// comparison plus scenario checks. A second instance with 2-bit counters
// shares all inputs to exercise counter saturation.
module tb_lvds_rx_framer;
  localparam int H = 8, W = 32, LOCKF = 2, VW = 108;

  logic clk = 1'b0, rst = 1'b1, en = 1'b1, sy = 1'b0, full = 1'b0, clr = 1'b0;
  logic [1:0] dat = 2'b00;
  logic        wclk, push, lck;
  logic [W-1:0] data;
  logic [15:0] errc, ovfc;
  logic [1:0]  st;
  logic        wclk2, push2, lck2;
  logic [W-1:0] data2;
  logic [1:0]  errc2, ovfc2, st2;

  always #5 clk = ~clk;

  lvds_rx_framer #(.HALF_CYCLES(H), .LOCK_FRAMES(LOCKF), .CNT_W(16)) dut (
    .i_ddr_clk(clk), .i_rst(rst), .i_enable(en), .i_ddr_data(dat), .i_sync_input(sy),
    .i_fifo_full(full), .i_cnt_clear(clr), .o_fifo_write_clk(wclk), .o_fifo_push(push),
    .o_fifo_data(data), .o_locked(lck), .o_sync_err_cnt(errc), .o_overflow_cnt(ovfc),
    .o_debug_state(st));

  lvds_rx_framer #(.HALF_CYCLES(H), .LOCK_FRAMES(LOCKF), .CNT_W(2)) dut2 (
    .i_ddr_clk(clk), .i_rst(rst), .i_enable(en), .i_ddr_data(dat), .i_sync_input(sy),
    .i_fifo_full(full), .i_cnt_clear(clr), .o_fifo_write_clk(wclk2), .o_fifo_push(push2),
    .o_fifo_data(data2), .o_locked(lck2), .o_sync_err_cnt(errc2), .o_overflow_cnt(ovfc2),
    .o_debug_state(st2));

  int nchk = 0, nerr = 0, cyc = 0;

  // reference model: position inside the frame, -1 while hunting
  int          m_pos, m_good, m_err, m_ovf, m_err2, m_ovf2;
  longint      m_acc;
  logic        m_mk, m_locked, m_jd, m_push;
  logic [W-1:0] m_data;

  logic [VW-1:0] act_tr[$], exp_tr[$];
  int            cyc_tr[$];

  task automatic model_reset();
    m_pos = -1; m_good = 0; m_err = 0; m_ovf = 0; m_err2 = 0; m_ovf2 = 0;
    m_acc = 0; m_mk = 0; m_locked = 0; m_jd = 0; m_push = 0; m_data = '0;
  endtask

  task automatic model_step(input logic [1:0] s, input logic syv, input logic f,
                            input logic c, input logic e);
    bit e_ev, o_ev, done;
    e_ev = 0; o_ev = 0; done = 0; m_push = 0;
    if (!e) begin
      m_pos = -1; m_locked = 0; m_good = 0;
    end else if (m_pos < 0) begin
      if (s == 2'b10) begin m_pos = 0; m_acc = 2; m_mk = syv; end
      else if (m_locked && m_jd) begin e_ev = 1; m_locked = 0; m_good = 0; end
    end else begin
      m_pos++;
      if (m_pos == H && s != 2'b01) begin
        e_ev = 1; m_locked = 0; m_good = 0; m_pos = -1;
      end else if (m_pos < 2*H-1) begin
        m_acc = m_acc * 4 + longint'(s);
      end else begin
        m_data = 32'(m_acc * 4 + longint'({s[1], m_mk}));
        done = 1; m_pos = -1;
        if (!m_locked) begin m_good++; if (m_good >= LOCKF) m_locked = 1; end
        if (m_locked) begin if (f) o_ev = 1; else m_push = 1; end
      end
    end
    m_jd = done;
    if (c) begin
      m_err = 0; m_ovf = 0; m_err2 = 0; m_ovf2 = 0;
    end else begin
      if (e_ev) begin
        m_err  = (m_err < 65535) ? m_err + 1 : m_err;
        m_err2 = (m_err2 < 3) ? m_err2 + 1 : m_err2;
      end
      if (o_ev) begin
        m_ovf  = (m_ovf < 65535) ? m_ovf + 1 : m_ovf;
        m_ovf2 = (m_ovf2 < 3) ? m_ovf2 + 1 : m_ovf2;
      end
    end
  endtask

  function automatic logic [VW-1:0] obs();
    return {push, data, lck, st, errc, ovfc, push2, data2, lck2, st2, errc2, ovfc2};
  endfunction

  function automatic logic [VW-1:0] expv();
    logic [1:0] s;
    s = (m_pos < 0) ? 2'b00 : ((m_pos < H) ? 2'b01 : 2'b11);
    return {m_push, m_data, m_locked, s, 16'(m_err), 16'(m_ovf),
            m_push, m_data, m_locked, s, 2'(m_err2), 2'(m_ovf2)};
  endfunction

  task automatic tick(input logic [1:0] s, input logic syv, input logic f,
                      input logic c, input logic e);
    @(negedge clk);
    dat = s; sy = syv; full = f; clr = c; en = e;
    @(posedge clk);
    model_step(s, syv, f, c, e);
    #1;
    cyc++;
    act_tr.push_back(obs()); exp_tr.push_back(expv()); cyc_tr.push_back(cyc);
  endtask

  task automatic idle_rand(input int n);
    logic [1:0] s;
    for (int i = 0; i < n; i++) begin
      s = 2'($urandom_range(0, 2));
      if (s == 2'b10) s = 2'b11;
      tick(s, 1'($urandom), 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic send_frame(input logic [13:0] ip, input logic [12:0] qp, input logic mk,
                            input logic [1:0] qs, input logic f, input int nsym,
                            input int clr_at, input logic e);
    logic [31:0] w;
    logic [1:0]  s;
    w = {2'b10, ip, qs, qp, 1'b0};
    for (int k = 0; k < nsym; k++) begin
      s = w[31-2*k -: 2];
      if (k == 2*H-1) s[0] = 1'($urandom);
      tick(s, (k == 0) ? mk : 1'($urandom), f, (k == clr_at), e);
    end
  endtask

  task automatic good_frame(input logic f);
    send_frame(14'($urandom), 13'($urandom), 1'($urandom), 2'b01, f, 2*H, -1, 1'b1);
  endtask

  task automatic trace_diffs(output int nd, output int bc, output logic [VW-1:0] ba,
                             output logic [VW-1:0] be);
    nd = 0; bc = -1; ba = '0; be = '0;
    foreach (act_tr[i]) begin
      if (act_tr[i] !== exp_tr[i]) begin
        if (nd == 0) begin bc = cyc_tr[i]; ba = act_tr[i]; be = exp_tr[i]; end
        nd++;
      end
    end
    act_tr.delete(); exp_tr.delete(); cyc_tr.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (obs() !== '0) begin
      nerr++; $display("FAIL reset_outputs got %h want 0", obs());
    end
    nchk++;
    if (wclk !== clk) begin
      nerr++; $display("FAIL write_clk got %b want %b", wclk, clk);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_lock();
    logic [31:0] exp1;
    int c2, nd, bc;
    logic [VW-1:0] ba, be;
    exp1 = {2'b10, 14'h1555, 2'b01, 13'h0AAA, 1'b1};
    idle_rand(3);
    send_frame(14'h1555, 13'h0AAA, 1'b1, 2'b01, 1'b0, 2*H, -1, 1'b1);
    nchk++;
    if (push !== 1'b0 || lck !== 1'b0) begin
      nerr++; $display("FAIL lock_frame1 push=%b locked=%b want 0 0", push, lck);
    end
    send_frame(14'h1555, 13'h0AAA, 1'b1, 2'b01, 1'b0, 2*H, -1, 1'b1);
    c2 = cyc;
    nchk++;
    if (lck !== 1'b1) begin
      nerr++; $display("FAIL lock_frame2 locked=%b want 1", lck);
    end
    nchk++;
    if (push !== 1'b1 || data !== exp1) begin
      nerr++; $display("FAIL lock_push2 push=%b data=%h want 1 %h", push, data, exp1);
    end
    send_frame(14'h1555, 13'h0AAA, 1'b1, 2'b01, 1'b0, 2*H, -1, 1'b1);
    nchk++;
    if (push !== 1'b1 || cyc - c2 != 2*H) begin
      nerr++; $display("FAIL lock_push3 push=%b gap=%0d want 1 %0d", push, cyc - c2, 2*H);
    end
    trace_diffs(nd, bc, ba, be);
    nchk++;
    if (nd != 0) begin
      nerr++; $display("FAIL lock_trace %0d cycles, first cyc %0d got %h want %h", nd, bc, ba, be);
    end
  endtask

  task automatic test_random();
    int nd, bc;
    logic [VW-1:0] ba, be;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) idle_rand($urandom_range(1, 2));
      good_frame($urandom_range(0, 3) == 0);
    end
    trace_diffs(nd, bc, ba, be);
    nchk++;
    if (nd != 0) begin
      nerr++; $display("FAIL random_trace %0d cycles, first cyc %0d got %h want %h", nd, bc, ba, be);
    end
  endtask

  task automatic test_sync_err();
    int nd, bc;
    logic [VW-1:0] ba, be;
    tick(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    good_frame(1'b0);
    good_frame(1'b0);
    nchk++;
    if (lck !== 1'b1) begin
      nerr++; $display("FAIL syncerr_prelock locked=%b want 1", lck);
    end
    send_frame(14'($urandom), 13'($urandom), 1'b0, 2'b11, 1'b0, H+1, -1, 1'b1);
    nchk++;
    if (errc !== 16'd1 || lck !== 1'b0 || st !== 2'b00) begin
      nerr++; $display("FAIL syncerr_badq err=%0d locked=%b state=%b want 1 0 00", errc, lck, st);
    end
    good_frame(1'b0);
    nchk++;
    if (push !== 1'b0) begin
      nerr++; $display("FAIL syncerr_relock1 push=%b want 0", push);
    end
    good_frame(1'b0);
    nchk++;
    if (push !== 1'b1 || lck !== 1'b1) begin
      nerr++; $display("FAIL syncerr_relock2 push=%b locked=%b want 1 1", push, lck);
    end
    trace_diffs(nd, bc, ba, be);
    nchk++;
    if (nd != 0) begin
      nerr++; $display("FAIL syncerr_trace %0d cycles, first cyc %0d got %h want %h", nd, bc, ba, be);
    end
  endtask

  task automatic test_overflow();
    int nd, bc;
    logic [VW-1:0] ba, be;
    tick(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    good_frame(1'b0);
    good_frame(1'b0);
    good_frame(1'b1);
    nchk++;
    if (push !== 1'b0 || ovfc !== 16'd1) begin
      nerr++; $display("FAIL ovf_first push=%b ovf=%0d want 0 1", push, ovfc);
    end
    good_frame(1'b1);
    nchk++;
    if (push !== 1'b0 || ovfc !== 16'd2) begin
      nerr++; $display("FAIL ovf_second push=%b ovf=%0d want 0 2", push, ovfc);
    end
    good_frame(1'b0);
    nchk++;
    if (push !== 1'b1 || ovfc !== 16'd2) begin
      nerr++; $display("FAIL ovf_restore push=%b ovf=%0d want 1 2", push, ovfc);
    end
    trace_diffs(nd, bc, ba, be);
    nchk++;
    if (nd != 0) begin
      nerr++; $display("FAIL ovf_trace %0d cycles, first cyc %0d got %h want %h", nd, bc, ba, be);
    end
  endtask

  task automatic test_idle_err();
    tick(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    nchk++;
    if (errc !== 16'd1 || lck !== 1'b0) begin
      nerr++; $display("FAIL idle_first err=%0d locked=%b want 1 0", errc, lck);
    end
    repeat (10) tick(2'b00, 1'($urandom), 1'b0, 1'b0, 1'b1);
    nchk++;
    if (errc !== 16'd1) begin
      nerr++; $display("FAIL idle_repeat err=%0d want 1", errc);
    end
  endtask

  task automatic test_enable();
    int nd, bc;
    logic [VW-1:0] ba, be;
    good_frame(1'b0);
    good_frame(1'b0);
    send_frame(14'($urandom), 13'($urandom), 1'b1, 2'b11, 1'b0, 2*H, -1, 1'b0);
    nchk++;
    if (lck !== 1'b0 || push !== 1'b0 || st !== 2'b00 || errc !== 16'd1) begin
      nerr++; $display("FAIL enable_off locked=%b push=%b state=%b err=%0d want 0 0 00 1",
                       lck, push, st, errc);
    end
    idle_rand(3);
    trace_diffs(nd, bc, ba, be);
    nchk++;
    if (nd != 0) begin
      nerr++; $display("FAIL enable_trace %0d cycles, first cyc %0d got %h want %h", nd, bc, ba, be);
    end
  endtask

  task automatic test_reset_mid();
    int nd, bc;
    logic [VW-1:0] ba, be;
    good_frame(1'b0);
    good_frame(1'b0);
    send_frame(14'h3FFF, 13'h1FFF, 1'b1, 2'b01, 1'b0, 6, -1, 1'b1);
    #1 rst = 1'b1;
    #1;
    nchk++;
    if (obs() !== '0) begin
      nerr++; $display("FAIL reset_async got %h want 0", obs());
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_rand(2);
    good_frame(1'b0);
    nchk++;
    if (push !== 1'b0 || lck !== 1'b0) begin
      nerr++; $display("FAIL reset_relock1 push=%b locked=%b want 0 0", push, lck);
    end
    good_frame(1'b0);
    nchk++;
    if (push !== 1'b1 || lck !== 1'b1) begin
      nerr++; $display("FAIL reset_relock2 push=%b locked=%b want 1 1", push, lck);
    end
    trace_diffs(nd, bc, ba, be);
    nchk++;
    if (nd != 0) begin
      nerr++; $display("FAIL resetmid_trace %0d cycles, first cyc %0d got %h want %h", nd, bc, ba, be);
    end
  endtask

  task automatic test_saturate();
    int nd, bc;
    logic [VW-1:0] ba, be;
    tick(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (5) send_frame(14'($urandom), 13'($urandom), 1'b0, 2'b00, 1'b0, H+1, -1, 1'b1);
    nchk++;
    if (errc2 !== 2'd3 || errc !== 16'd5) begin
      nerr++; $display("FAIL sat_hold err2=%0d err=%0d want 3 5", errc2, errc);
    end
    send_frame(14'($urandom), 13'($urandom), 1'b0, 2'b11, 1'b0, H+1, H, 1'b1);
    nchk++;
    if (errc2 !== 2'd0 || errc !== 16'd0) begin
      nerr++; $display("FAIL sat_clear err2=%0d err=%0d want 0 0", errc2, errc);
    end
    trace_diffs(nd, bc, ba, be);
    nchk++;
    if (nd != 0) begin
      nerr++; $display("FAIL sat_trace %0d cycles, first cyc %0d got %h want %h", nd, bc, ba, be);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_random();
    test_sync_err();
    test_overflow();
    test_idle_err();
    test_enable();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
